// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for the hazard/stall controller.
// The pipeline is the master: it drives the ID/EX decode info and consumes stall/flush.
interface hazard_ctrl_if;
  logic [4:0] rf_ra0_id;
  logic [4:0] rf_ra1_id;
  logic       rf_re0_id;
  logic       rf_re1_id;
  logic       rf_we_id;
  logic [4:0] rf_wa_id;
  logic       is_div_id;
  logic       rf_we_ex;
  logic [4:0] rf_wa_ex;
  logic       mem_rd_ex;
  logic       div_start_ex;
  logic       br_taken_ex;
  logic       stall_if;
  logic       stall_id;
  logic       flush_id;
  logic       flush_ex;
  logic       div_busy;
  logic       div_wb_valid;
  logic [4:0] div_wb_addr;
  logic       div_err;

  modport master (
    output rf_ra0_id, rf_ra1_id, rf_re0_id, rf_re1_id, rf_we_id, rf_wa_id, is_div_id,
           rf_we_ex, rf_wa_ex, mem_rd_ex, div_start_ex, br_taken_ex,
    input  stall_if, stall_id, flush_id, flush_ex, div_busy, div_wb_valid, div_wb_addr, div_err
  );

  modport slave (
    input  rf_ra0_id, rf_ra1_id, rf_re0_id, rf_re1_id, rf_we_id, rf_wa_id, is_div_id,
           rf_we_ex, rf_wa_ex, mem_rd_ex, div_start_ex, br_taken_ex,
    output stall_if, stall_id, flush_id, flush_ex, div_busy, div_wb_valid, div_wb_addr, div_err
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage core.
// Covers load-use, the divider register scoreboard (RAW/WAW/structural) and taken-branch
// flushes; forwarding handles every other data hazard in EX.
module hazard_ctrl #(
  parameter int DIV_LAT = 8,
  parameter int CNT_W   = 5
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  logic [31:0]      pending;
  logic [31:0]      pending_nxt;
  logic [CNT_W-1:0] div_cnt;
  logic [4:0]       div_dst;
  logic             div_busy;
  logic             div_done;
  logic             issue_ok;
  logic             issue_bad;
  logic             load_use;
  logic             sb_hit;
  logic             hold;

  assign div_busy  = (div_cnt != '0);
  assign div_done  = (div_cnt == CNT_W'(1));
  assign issue_ok  = hz.div_start_ex & ~div_busy;
  assign issue_bad = hz.div_start_ex & div_busy;

  // Hazard detection: load result not forwardable yet, or operand/destination still owned by the divider.
  always_comb begin
    load_use = hz.rf_we_ex & hz.mem_rd_ex & (hz.rf_wa_ex != 5'd0) &
               ((hz.rf_re0_id & (hz.rf_ra0_id == hz.rf_wa_ex)) |
                (hz.rf_re1_id & (hz.rf_ra1_id == hz.rf_wa_ex)));
    sb_hit   = (hz.rf_re0_id & pending[hz.rf_ra0_id]) |
               (hz.rf_re1_id & pending[hz.rf_ra1_id]) |
               (hz.rf_we_id  & pending[hz.rf_wa_id])  |
               (hz.is_div_id & div_busy);
    hold     = load_use | sb_hit;
  end

  // Stall/flush enables; a taken branch squashes the ID instruction so its hazards are moot.
  always_comb begin
    hz.stall_if = 1'b0;
    hz.stall_id = 1'b0;
    hz.flush_id = 1'b0;
    hz.flush_ex = 1'b0;
    if (hz.br_taken_ex) begin
      hz.flush_id = 1'b1;
      hz.flush_ex = 1'b1;
    end else if (hold) begin
      hz.stall_if = 1'b1;
      hz.stall_id = 1'b1;
      hz.flush_ex = 1'b1;
    end
  end

  // Scoreboard update: completion clears first, a new issue sets after so set wins.
  always_comb begin
    pending_nxt = pending;
    if (div_done)
      pending_nxt[div_dst] = 1'b0;
    if (issue_ok && hz.rf_wa_ex != 5'd0)
      pending_nxt[hz.rf_wa_ex] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // Divider tracking: countdown, destination capture, writeback announcement, sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending         <= '0;
      div_cnt         <= '0;
      div_dst         <= '0;
      hz.div_wb_valid <= 1'b0;
      hz.div_wb_addr  <= '0;
      hz.div_err      <= 1'b0;
    end else begin
      pending         <= pending_nxt;
      hz.div_wb_valid <= div_done;
      if (div_done)
        hz.div_wb_addr <= div_dst;
      if (issue_ok) begin
        div_cnt <= CNT_W'(DIV_LAT);
        div_dst <= hz.rf_wa_ex;
      end else if (div_busy) begin
        div_cnt <= div_cnt - CNT_W'(1);
      end
      if (issue_bad)
        hz.div_err <= 1'b1;
    end
  end

  assign hz.div_busy = div_busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: combinational stall/flush checks inline,
// divider writebacks checked against a scoreboard of expected (addr, cycle) pairs.
module tb_hazard_ctrl;
  localparam int DIV_LAT = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;

  typedef struct {
    logic [4:0] addr;
    int         due;
  } wb_exp_t;

  wb_exp_t sb_q[$];

  hazard_ctrl_if hz ();

  hazard_ctrl #(.DIV_LAT(DIV_LAT), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Writeback monitor: every pulse must match the oldest outstanding issue, on its due cycle.
  always @(negedge clk) begin
    if (!rst && hz.div_wb_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got div_wb_valid=1 addr=%0d, expected no writeback", hz.div_wb_addr);
      end else begin
        wb_exp_t e;
        e = sb_q.pop_front();
        if (hz.div_wb_addr !== e.addr || cyc != e.due) begin
          errors++;
          $display("FAIL wb_match: got addr=%0d cycle=%0d, expected addr=%0d cycle=%0d",
                   hz.div_wb_addr, cyc, e.addr, e.due);
        end
      end
    end
  end

  task automatic drive_idle();
    hz.rf_ra0_id    = '0;
    hz.rf_ra1_id    = '0;
    hz.rf_re0_id    = 1'b0;
    hz.rf_re1_id    = 1'b0;
    hz.rf_we_id     = 1'b0;
    hz.rf_wa_id     = '0;
    hz.is_div_id    = 1'b0;
    hz.rf_we_ex     = 1'b0;
    hz.rf_wa_ex     = '0;
    hz.mem_rd_ex    = 1'b0;
    hz.div_start_ex = 1'b0;
    hz.br_taken_ex  = 1'b0;
  endtask

  // Issues an accepted divide across the next edge; returns at the following negedge.
  task automatic issue_div(input logic [4:0] dst);
    wb_exp_t e;
    hz.div_start_ex = 1'b1;
    hz.rf_wa_ex     = dst;
    e.addr = dst;
    e.due  = cyc + 1 + DIV_LAT;
    sb_q.push_back(e);
    @(negedge clk);
    hz.div_start_ex = 1'b0;
    hz.rf_wa_ex     = '0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d writebacks outstanding after 20 cycles, expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    logic [7:0] got;
    rst = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    #1;
    got = {hz.stall_if, hz.stall_id, hz.flush_id, hz.flush_ex,
           hz.div_busy, hz.div_wb_valid, hz.div_err, (hz.div_wb_addr != 5'd0)};
    checks++;
    if (got !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected 00000000", got);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_use();
    logic [2:0] exp_v;
    logic [2:0] got;
    // {rf_wa_ex, re0, ra0, re1, ra1, mem_rd} -> expected {stall_if, stall_id, flush_ex}
    for (int i = 0; i < 5; i++) begin
      drive_idle();
      hz.rf_we_ex = 1'b1;
      hz.mem_rd_ex = 1'b1;
      case (i)
        0: begin hz.rf_wa_ex = 5'd5; hz.rf_re1_id = 1'b1; hz.rf_ra1_id = 5'd5; exp_v = 3'b111; end
        1: begin hz.rf_wa_ex = 5'd0; hz.rf_re1_id = 1'b1; hz.rf_ra1_id = 5'd0; exp_v = 3'b000; end
        2: begin hz.rf_wa_ex = 5'd9; hz.rf_re0_id = 1'b1; hz.rf_ra0_id = 5'd9; exp_v = 3'b111; end
        3: begin hz.rf_wa_ex = 5'd9; hz.rf_re0_id = 1'b0; hz.rf_ra0_id = 5'd9; exp_v = 3'b000; end
        default: begin hz.rf_wa_ex = 5'd9; hz.mem_rd_ex = 1'b0; hz.rf_re0_id = 1'b1; hz.rf_ra0_id = 5'd9; exp_v = 3'b000; end
      endcase
      #1;
      got = {hz.stall_if, hz.stall_id, hz.flush_ex};
      checks++;
      if (got !== exp_v || hz.flush_id !== 1'b0) begin
        errors++;
        $display("FAIL load_use_%0d: got stall_if,stall_id,flush_ex=%b flush_id=%b, expected %b flush_id=0",
                 i, got, hz.flush_id, exp_v);
      end
      @(negedge clk);
    end
    drive_idle();
  endtask

  task automatic test_div_scoreboard();
    issue_div(5'd7);
    hz.rf_re0_id = 1'b1;
    hz.rf_ra0_id = 5'd7;
    for (int k = 0; k < DIV_LAT; k++) begin
      #1;
      checks++;
      if (hz.div_busy !== 1'b1 || hz.stall_if !== 1'b1 || hz.stall_id !== 1'b1 || hz.flush_ex !== 1'b1) begin
        errors++;
        $display("FAIL div_hold_k%0d: got busy=%b stall_if=%b stall_id=%b flush_ex=%b, expected all 1",
                 k, hz.div_busy, hz.stall_if, hz.stall_id, hz.flush_ex);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (hz.div_busy !== 1'b0 || hz.stall_if !== 1'b0 || hz.div_wb_valid !== 1'b1) begin
      errors++;
      $display("FAIL div_complete: got busy=%b stall_if=%b wb_valid=%b, expected 0 0 1",
               hz.div_busy, hz.stall_if, hz.div_wb_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (hz.div_wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL div_wb_one_cycle: got wb_valid=%b, expected 0", hz.div_wb_valid);
    end
    drive_idle();
    wait_drain("div");
  endtask

  task automatic test_waw_struct();
    logic exp_s;
    issue_div(5'd7);
    hz.rf_we_id = 1'b1;
    hz.rf_wa_id = 5'd7;
    #1;
    checks++;
    if (hz.stall_if !== 1'b1) begin
      errors++;
      $display("FAIL waw_stall: got stall_if=%b, expected 1", hz.stall_if);
    end
    @(negedge clk);
    hz.rf_we_id  = 1'b0;
    hz.is_div_id = 1'b1;
    hz.rf_wa_id  = 5'd9;
    for (int k = 1; k < DIV_LAT + 2; k++) begin
      exp_s = (k < DIV_LAT);
      #1;
      checks++;
      if (hz.stall_if !== exp_s) begin
        errors++;
        $display("FAIL struct_stall_k%0d: got stall_if=%b, expected %b", k, hz.stall_if, exp_s);
      end
      @(negedge clk);
    end
    drive_idle();
    wait_drain("waw");
  endtask

  task automatic test_branch();
    logic [3:0] got;
    issue_div(5'd3);
    hz.rf_we_ex    = 1'b1;
    hz.mem_rd_ex   = 1'b1;
    hz.rf_wa_ex    = 5'd5;
    hz.rf_re1_id   = 1'b1;
    hz.rf_ra1_id   = 5'd5;
    hz.rf_re0_id   = 1'b1;
    hz.rf_ra0_id   = 5'd3;
    hz.br_taken_ex = 1'b1;
    #1;
    got = {hz.flush_id, hz.flush_ex, hz.stall_if, hz.stall_id};
    checks++;
    if (got !== 4'b1100) begin
      errors++;
      $display("FAIL branch_priority: got flush_id,flush_ex,stall_if,stall_id=%b, expected 1100", got);
    end
    hz.br_taken_ex = 1'b0;
    #1;
    got = {hz.flush_id, hz.flush_ex, hz.stall_if, hz.stall_id};
    checks++;
    if (got !== 4'b0111) begin
      errors++;
      $display("FAIL branch_released: got flush_id,flush_ex,stall_if,stall_id=%b, expected 0111", got);
    end
    @(negedge clk);
    drive_idle();
    wait_drain("branch");
  endtask

  task automatic test_error();
    issue_div(5'd10);
    hz.div_start_ex = 1'b1;
    hz.rf_wa_ex     = 5'd11;
    @(negedge clk);
    hz.div_start_ex = 1'b0;
    hz.rf_wa_ex     = '0;
    #1;
    checks++;
    if (hz.div_err !== 1'b1 || hz.div_busy !== 1'b1) begin
      errors++;
      $display("FAIL err_set: got div_err=%b busy=%b, expected 1 1", hz.div_err, hz.div_busy);
    end
    hz.rf_re0_id = 1'b1;
    hz.rf_ra0_id = 5'd11;
    #1;
    checks++;
    if (hz.stall_if !== 1'b0) begin
      errors++;
      $display("FAIL err_no_pending: got stall_if=%b reading x11, expected 0", hz.stall_if);
    end
    hz.rf_ra0_id = 5'd10;
    #1;
    checks++;
    if (hz.stall_if !== 1'b1) begin
      errors++;
      $display("FAIL err_dst_kept: got stall_if=%b reading x10, expected 1", hz.stall_if);
    end
    drive_idle();
    wait_drain("err");
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (hz.div_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got div_err=%b after 20 cycles, expected 1", hz.div_err);
    end
  endtask

  task automatic test_back_to_back();
    issue_div(5'd4);
    repeat (DIV_LAT) @(negedge clk);
    #1;
    checks++;
    if (hz.div_wb_valid !== 1'b1 || hz.div_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first_done: got wb_valid=%b busy=%b, expected 1 0", hz.div_wb_valid, hz.div_busy);
    end
    issue_div(5'd6);
    hz.rf_re0_id = 1'b1;
    hz.rf_ra0_id = 5'd4;
    #1;
    checks++;
    if (hz.div_busy !== 1'b1 || hz.stall_if !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_issue: got busy=%b stall_if=%b reading x4, expected 1 0", hz.div_busy, hz.stall_if);
    end
    hz.rf_ra0_id = 5'd6;
    #1;
    checks++;
    if (hz.stall_if !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pending6: got stall_if=%b reading x6, expected 1", hz.stall_if);
    end
    drive_idle();
    wait_drain("b2b");
  endtask

  task automatic test_reset_mid();
    issue_div(5'd12);
    repeat (5) @(negedge clk);
    hz.rf_re0_id = 1'b1;
    hz.rf_ra0_id = 5'd12;
    #1;
    checks++;
    if (hz.stall_if !== 1'b1 || hz.div_busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: got stall_if=%b busy=%b, expected 1 1", hz.stall_if, hz.div_busy);
    end
    rst = 1'b1;
    #1;
    sb_q.delete();
    checks++;
    if (hz.div_busy !== 1'b0 || hz.div_err !== 1'b0 || hz.stall_if !== 1'b0 || hz.flush_ex !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_clear: got busy=%b err=%b stall_if=%b flush_ex=%b, expected all 0",
               hz.div_busy, hz.div_err, hz.stall_if, hz.flush_ex);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (hz.div_wb_valid !== 1'b0 || hz.stall_if !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_quiet_k%0d: got wb_valid=%b stall_if=%b, expected 0 0", k, hz.div_wb_valid, hz.stall_if);
      end
    end
    drive_idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst    = 1'b1;
    drive_idle();
    test_reset();
    test_load_use();
    test_div_scoreboard();
    test_waw_struct();
    test_branch();
    test_error();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
